// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op decode for the alu32 arbiter slice.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned ST_W   = 2;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_NOR = 3'd5;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_EXEC = 2'd1;
    localparam logic [ST_W-1:0] ST_RESP = 2'd2;

    // One strobe per alu32 operation; at most one is set.
    typedef struct packed {
        logic op_add;
        logic op_sub;
        logic op_and;
        logic op_or;
        logic op_xor;
        logic op_nor;
    } alu_strobe_t;

    // Map an op code to its one-hot strobe set; codes 6 and 7 yield no strobe.
    function automatic alu_strobe_t op_decode(input logic [OP_W-1:0] op);
        alu_strobe_t s;
        s = '0;
        case (op)
            OP_ADD:  s.op_add = 1'b1;
            OP_SUB:  s.op_sub = 1'b1;
            OP_AND:  s.op_and = 1'b1;
            OP_OR:   s.op_or  = 1'b1;
            OP_XOR:  s.op_xor = 1'b1;
            OP_NOR:  s.op_nor = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    // Flag op codes outside the defined ADD..NOR range.
    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return (op > OP_NOR);
    endfunction

endpackage

// File: rtl/alu32.sv
// Combinational 32-bit ALU driven by one-hot op strobes.
module alu32
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              op_add,
    input  logic              op_sub,
    input  logic              op_and,
    input  logic              op_or,
    input  logic              op_xor,
    input  logic              op_nor,
    output logic [DATA_W-1:0] out_c,
    output logic              overflow_c,
    output logic              zero_c
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Select the strobed result; signed overflow only exists for add/sub.
    always_comb begin
        out_c      = '0;
        overflow_c = 1'b0;
        if (op_add) begin
            out_c      = sum;
            overflow_c = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        end else if (op_sub) begin
            out_c      = diff;
            overflow_c = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
        end else if (op_and) begin
            out_c = a & b;
        end else if (op_or) begin
            out_c = a | b;
        end else if (op_xor) begin
            out_c = a ^ b;
        end else if (op_nor) begin
            out_c = ~(a | b);
        end
    end

    assign zero_c = (out_c == '0);

endmodule

// File: rtl/alu32_arbiter.sv
// Round-robin sharing of one alu32 between two requesters with a registered response.
module alu32_arbiter
    import alu_pkg::*;
#(
    parameter bit RESET_PTR = 1'b0
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_out,
    output logic              rsp_overflow,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic              ovf_sticky,
    input  logic              ovf_clear,
    output logic              busy
);

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_next;
    logic              ptr;
    logic              grant_id;
    logic              accept;

    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              id_q;

    alu_strobe_t       strobe;
    logic              illegal;
    logic [DATA_W-1:0] alu_out;
    logic              alu_ovf;
    logic              alu_zero;

    assign strobe  = op_decode(op_q);
    assign illegal = op_illegal(op_q);

    alu32 u_alu (
        .a          (a_q),
        .b          (b_q),
        .op_add     (strobe.op_add),
        .op_sub     (strobe.op_sub),
        .op_and     (strobe.op_and),
        .op_or      (strobe.op_or),
        .op_xor     (strobe.op_xor),
        .op_nor     (strobe.op_nor),
        .out_c      (alu_out),
        .overflow_c (alu_ovf),
        .zero_c     (alu_zero)
    );

    // Grant selection and next-state decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        grant_id   = ptr;
        if (req0_valid && !req1_valid) begin
            grant_id = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant_id = 1'b1;
        end
        case (state)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Ready is a same-cycle acknowledge; held low while reset is asserted.
    assign req0_ready = accept && !grant_id && !p_reset;
    assign req1_ready = accept && grant_id && !p_reset;

    // State register; busy is registered alongside it.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
        end
    end

    // Latch the granted operation on the accept edge.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            id_q <= 1'b0;
        end else if (accept) begin
            op_q <= grant_id ? req1_op : req0_op;
            a_q  <= grant_id ? req1_a  : req0_a;
            b_q  <= grant_id ? req1_b  : req0_b;
            id_q <= grant_id;
        end
    end

    // Capture the ALU result at the end of EXEC and hold it until consumed.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_out      <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_illegal  <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_valid    <= 1'b1;
            rsp_id       <= id_q;
            rsp_out      <= illegal ? '0 : alu_out;
            rsp_overflow <= illegal ? 1'b0 : alu_ovf;
            rsp_zero     <= illegal ? 1'b1 : alu_zero;
            rsp_illegal  <= illegal;
        end else if ((state == ST_RESP) && rsp_ready) begin
            rsp_valid    <= 1'b0;
        end
    end

    // Round-robin pointer favours the other requester after each delivery.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            ptr <= RESET_PTR;
        end else if ((state == ST_RESP) && rsp_ready) begin
            ptr <= ~rsp_id;
        end
    end

    // Sticky overflow; a capture on the same edge as a clear keeps it set.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            ovf_sticky <= 1'b0;
        end else if ((state == ST_EXEC) && alu_ovf && !illegal) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clear) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu32_arbiter.sv
// Directed bench for alu32_arbiter: handshake, arbitration, flags and reset.
module tb_alu32_arbiter;

    logic        m_clock;
    logic        p_reset;
    logic        req0_valid, req0_ready;
    logic [2:0]  req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [2:0]  req1_op;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_out;
    logic        rsp_overflow, rsp_zero, rsp_illegal;
    logic        ovf_sticky, ovf_clear, busy;

    int n_cmp;
    int n_err;

    alu32_arbiter #(.RESET_PTR(1'b0)) dut (
        .m_clock      (m_clock),
        .p_reset      (p_reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op      (req0_op),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op      (req1_op),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_out      (rsp_out),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .rsp_illegal  (rsp_illegal),
        .ovf_sticky   (ovf_sticky),
        .ovf_clear    (ovf_clear),
        .busy         (busy)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    task automatic test_reset();
        p_reset = 1'b1;
        req0_valid = 1'b0; req0_op = 3'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0; ovf_clear = 1'b0;
        repeat (2) @(posedge m_clock);
        @(negedge m_clock);
        p_reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (rsp_out !== 32'h0) begin n_err++; $display("FAIL rst_rsp_out got=%h exp=0", rsp_out); end
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL rst_sticky got=%b exp=0", ovf_sticky); end
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL rst_ready got=%b exp=00", {req0_ready, req1_ready}); end
    endtask

    task automatic test_add_overflow();
        @(negedge m_clock);
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'h7FFF_FFFF; req0_b = 32'h0000_0001;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL add_ready got=%b exp=10", {req0_ready, req1_ready}); end
        @(posedge m_clock); @(negedge m_clock);
        req0_valid = 1'b0;
        #1;
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL add_ready_exec got=%b exp=0", req0_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL add_busy got=%b exp=1", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_early_valid got=%b exp=0", rsp_valid); end
        @(posedge m_clock); @(negedge m_clock);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got=%b exp=1", rsp_valid); end
        n_cmp++; if (rsp_out !== 32'h8000_0000) begin n_err++; $display("FAIL add_out got=%h exp=80000000", rsp_out); end
        n_cmp++; if (rsp_overflow !== 1'b1) begin n_err++; $display("FAIL add_ovf got=%b exp=1", rsp_overflow); end
        n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL add_id got=%b exp=0", rsp_id); end
        n_cmp++; if ({rsp_zero, rsp_illegal} !== 2'b00) begin n_err++; $display("FAIL add_zero_ill got=%b exp=00", {rsp_zero, rsp_illegal}); end
        n_cmp++; if (ovf_sticky !== 1'b1) begin n_err++; $display("FAIL add_sticky got=%b exp=1", ovf_sticky); end
        @(posedge m_clock); @(negedge m_clock);
        n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_err++; $display("FAIL add_done got=%b exp=00", {rsp_valid, busy}); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 32'd5; req1_b = 32'd5;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL bp_ready got=%b exp=01", {req0_ready, req1_ready}); end
        @(posedge m_clock); @(negedge m_clock);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd1; req0_b = 32'd1;
        #1;
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_exec_grant got=%b exp=0", req0_ready); end
        @(posedge m_clock); @(negedge m_clock);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, rsp_valid); end
            n_cmp++; if (rsp_out !== 32'h0) begin n_err++; $display("FAIL bp_out[%0d] got=%h exp=0", i, rsp_out); end
            n_cmp++; if ({rsp_zero, rsp_id, rsp_overflow, rsp_illegal} !== 4'b1100) begin n_err++; $display("FAIL bp_flags[%0d] got=%b exp=1100", i, {rsp_zero, rsp_id, rsp_overflow, rsp_illegal}); end
            n_cmp++; if ({busy, req0_ready} !== 2'b10) begin n_err++; $display("FAIL bp_busy_grant[%0d] got=%b exp=10", i, {busy, req0_ready}); end
            if (i == 3) rsp_ready = 1'b1;
            @(posedge m_clock); @(negedge m_clock);
        end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got=%b exp=0", rsp_valid); end
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle_grant got=%b exp=1", req0_ready); end
        req0_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        logic        exp_id;
        logic [31:0] exp_out;
        p_reset = 1'b1;
        @(posedge m_clock); @(negedge m_clock);
        p_reset = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00;
        req1_valid = 1'b1; req1_op = 3'd5; req1_a = 32'h0; req1_b = 32'h0;
        for (int i = 0; i < 4; i++) begin
            exp_id  = ((i % 2) == 1);
            exp_out = exp_id ? 32'hFFFF_FFFF : 32'hF000_F000;
            #1;
            n_cmp++; if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin n_err++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, {req0_ready, req1_ready}, {~exp_id, exp_id}); end
            @(posedge m_clock); @(negedge m_clock);
            @(posedge m_clock); @(negedge m_clock);
            n_cmp++; if (rsp_id !== exp_id) begin n_err++; $display("FAIL rr_id[%0d] got=%b exp=%b", i, rsp_id, exp_id); end
            n_cmp++; if (rsp_out !== exp_out) begin n_err++; $display("FAIL rr_out[%0d] got=%h exp=%h", i, rsp_out, exp_out); end
            n_cmp++; if (rsp_overflow !== 1'b0) begin n_err++; $display("FAIL rr_ovf[%0d] got=%b exp=0", i, rsp_overflow); end
            @(posedge m_clock); @(negedge m_clock);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_illegal();
        req0_valid = 1'b1; req0_op = 3'd7; req0_a = 32'd3; req0_b = 32'd4;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL ill_ready got=%b exp=1", req0_ready); end
        @(posedge m_clock); @(negedge m_clock);
        req0_valid = 1'b0;
        @(posedge m_clock); @(negedge m_clock);
        n_cmp++; if (rsp_illegal !== 1'b1) begin n_err++; $display("FAIL ill_flag got=%b exp=1", rsp_illegal); end
        n_cmp++; if (rsp_out !== 32'h0) begin n_err++; $display("FAIL ill_out got=%h exp=0", rsp_out); end
        n_cmp++; if ({rsp_zero, rsp_overflow} !== 2'b10) begin n_err++; $display("FAIL ill_zero_ovf got=%b exp=10", {rsp_zero, rsp_overflow}); end
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL ill_sticky got=%b exp=0", ovf_sticky); end
        @(posedge m_clock); @(negedge m_clock);
    endtask

    task automatic test_ovf_clear();
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 32'h8000_0000; req0_b = 32'h0000_0001;
        @(posedge m_clock); @(negedge m_clock);
        req0_valid = 1'b0;
        ovf_clear = 1'b1;
        @(posedge m_clock); @(negedge m_clock);
        n_cmp++; if (rsp_out !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL clr_out got=%h exp=7fffffff", rsp_out); end
        n_cmp++; if (rsp_overflow !== 1'b1) begin n_err++; $display("FAIL clr_ovf got=%b exp=1", rsp_overflow); end
        n_cmp++; if (ovf_sticky !== 1'b1) begin n_err++; $display("FAIL clr_set_wins got=%b exp=1", ovf_sticky); end
        @(posedge m_clock); @(negedge m_clock);
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL clr_later got=%b exp=0", ovf_sticky); end
        ovf_clear = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'h7FFF_FFFF; req0_b = 32'h0000_0001;
        @(posedge m_clock); @(negedge m_clock);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got=%b exp=1", busy); end
        #1 p_reset = 1'b1;
        #1;
        n_cmp++; if ({busy, rsp_valid, ovf_sticky} !== 3'b000) begin n_err++; $display("FAIL mid_status got=%b exp=000", {busy, rsp_valid, ovf_sticky}); end
        n_cmp++; if (rsp_out !== 32'h0) begin n_err++; $display("FAIL mid_out got=%h exp=0", rsp_out); end
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready got=%b exp=0", req0_ready); end
        @(posedge m_clock); @(negedge m_clock);
        p_reset = 1'b0;
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge m_clock); @(negedge m_clock);
            n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_err++; $display("FAIL mid_no_rsp[%0d] got=%b exp=00", i, {rsp_valid, busy}); end
        end
        req0_valid = 1'b1; req0_op = 3'd4; req0_a = 32'h0000_00A5; req0_b = 32'h0000_000F;
        req1_valid = 1'b1; req1_op = 3'd3; req1_a = 32'h1;         req1_b = 32'h2;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL mid_first_grant got=%b exp=10", {req0_ready, req1_ready}); end
        @(posedge m_clock); @(negedge m_clock);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge m_clock); @(negedge m_clock);
        n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL mid_rsp_id got=%b exp=0", rsp_id); end
        n_cmp++; if (rsp_out !== 32'h0000_00AA) begin n_err++; $display("FAIL mid_rsp_out got=%h exp=000000aa", rsp_out); end
        @(posedge m_clock); @(negedge m_clock);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_add_overflow();
        test_backpressure();
        test_round_robin();
        test_illegal();
        test_ovf_clear();
        test_reset_mid_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
